// File: rtl/or_selftest_seq.sv
// Self-test sequencer for a two-input OR gate: walks A/B through 00,01,10,11,
// samples C at a fixed settle point in each dwell and reports a fail mask / pass flag.
module or_selftest_seq #(
    parameter int DWELL  = 8,
    parameter int SETTLE = 2,
    parameter int CNT_W  = 16
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       START,
    input  logic       CONTINUOUS,
    input  logic       C,
    output logic       A,
    output logic       B,
    output logic [1:0] VEC,
    output logic       BUSY,
    output logic       DONE,
    output logic       PASS,
    output logic [3:0] FAIL_MASK
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_FINISH = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LP_SETTLE = CNT_W'(SETTLE);
    localparam logic [CNT_W-1:0] LP_LAST   = CNT_W'(DWELL - 1);

    state_t           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic [1:0]       r_vec, w_vec_nxt;
    logic [3:0]       r_mask, w_mask_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_done, w_done_nxt;
    logic             r_pass, w_pass_nxt;
    logic             w_launch;
    logic             w_expect;

    // Gate inputs come straight from the vector register, so A/B are registered
    // and return to 0 whenever VEC does.
    assign w_expect = r_vec[1] | r_vec[0];

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_vec_nxt   = r_vec;
        w_mask_nxt  = r_mask;
        w_pass_nxt  = r_pass;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        w_launch    = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_launch = START;
            end
            S_RUN: begin
                w_busy_nxt = 1'b1;
                w_cnt_nxt  = r_cnt + CNT_W'(1);
                if (r_cnt == LP_SETTLE) begin
                    w_mask_nxt[r_vec] = (C != w_expect);
                end
                if (r_cnt == LP_LAST) begin
                    w_cnt_nxt = '0;
                    if (r_vec != 2'd3) begin
                        w_vec_nxt = r_vec + 2'd1;
                    end else begin
                        // Uses the next-mask so a sample on the last dwell cycle still counts.
                        w_state_nxt = S_FINISH;
                        w_vec_nxt   = 2'd0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_pass_nxt  = (w_mask_nxt == 4'b0000);
                    end
                end
            end
            S_FINISH: begin
                w_launch = START | CONTINUOUS;
                if (!w_launch) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        if (w_launch) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = '0;
            w_vec_nxt   = 2'd0;
            w_mask_nxt  = 4'b0000;
            w_busy_nxt  = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_vec   <= 2'd0;
            r_mask  <= 4'b0000;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_pass  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_vec   <= w_vec_nxt;
            r_mask  <= w_mask_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_pass  <= w_pass_nxt;
        end
    end

    assign A         = r_vec[1];
    assign B         = r_vec[0];
    assign VEC       = r_vec;
    assign BUSY      = r_busy;
    assign DONE      = r_done;
    assign PASS      = r_pass;
    assign FAIL_MASK = r_mask;

endmodule

// File: tb/tb_or_selftest_seq.sv
// Bench for or_selftest_seq: a timing-level reference model predicts each run's
// outputs; a monitor compares every cycle and scoreboards each DONE against queued results.
module tb_or_selftest_seq;

    localparam int D = 8;
    localparam int S = 2;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b1;
    logic       START = 1'b0;
    logic       CONTINUOUS = 1'b0;
    logic       C = 1'b0;
    logic       A, B, BUSY, DONE, PASS;
    logic [1:0] VEC;
    logic [3:0] FAIL_MASK;

    or_selftest_seq #(.DWELL(D), .SETTLE(S), .CNT_W(16)) dut (
        .CLK(CLK), .RST_N(RST_N), .START(START), .CONTINUOUS(CONTINUOUS), .C(C),
        .A(A), .B(B), .VEC(VEC), .BUSY(BUSY), .DONE(DONE), .PASS(PASS),
        .FAIL_MASK(FAIL_MASK)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Gate under test: mode 0 = OR, 1 = stuck-at-0, 2 = AND.
    function automatic logic gate(input int mode, input logic a, input logic b);
        case (mode)
            1:       return 1'b0;
            2:       return a & b;
            default: return a | b;
        endcase
    endfunction

    // Vector k applies A=k[1], B=k[0]; bit k fails if the sampled C differs from A|B.
    function automatic logic [3:0] predict(input int mode, input logic [3:0] flip);
        logic [3:0] m;
        logic [1:0] kv;
        logic       c;
        for (int k = 0; k < 4; k++) begin
            kv   = 2'(k);
            c    = gate(mode, kv[1], kv[0]) ^ flip[k];
            m[k] = (c != (kv[1] | kv[0]));
        end
        return m;
    endfunction

    typedef struct {
        logic [3:0] mask;
        logic       pass;
        int         done_edge;
    } exp_t;
    exp_t sb_q[$];

    // Stimulus-side configuration, latched by the model when a run starts.
    int         cfg_mode = 0;
    logic [3:0] cfg_flip = 4'b0000;
    logic       cfg_noise = 1'b0;

    bit         m_active = 1'b0;
    int         m_t = 0;
    logic       m_pass = 1'b0;
    logic [3:0] m_mask = 4'b0000;
    int         run_mode = 0;
    logic [3:0] run_flip = 4'b0000;
    logic [3:0] run_mask = 4'b0000;
    logic       run_noise = 1'b0;

    // Reference model: a run started at edge t lasts 4*D cycles plus one FINISH cycle.
    always @(posedge CLK) begin
        int   rel_edge;
        bit   go;
        exp_t e;
        cyc = cyc + 1;
        go  = 1'b0;
        if (!RST_N) begin
            m_active = 1'b0;
            m_pass   = 1'b0;
            m_mask   = 4'b0000;
            sb_q.delete();
        end else begin
            if (m_active) begin
                rel_edge = cyc - m_t;
                for (int k = 0; k < 4; k++)
                    if (rel_edge == 1 + k * D + S) m_mask[k] = run_mask[k];
                if (rel_edge == 4 * D) m_pass = (run_mask == 4'b0000);
                if (rel_edge == 4 * D + 1) begin
                    m_active = 1'b0;
                    go = START | CONTINUOUS;
                end
            end else begin
                go = START;
            end
            if (go) begin
                m_active  = 1'b1;
                m_t       = cyc;
                m_mask    = 4'b0000;
                run_mode  = cfg_mode;
                run_flip  = cfg_flip;
                run_noise = cfg_noise;
                run_mask  = predict(cfg_mode, cfg_flip);
                e.mask      = run_mask;
                e.pass      = (run_mask == 4'b0000);
                e.done_edge = cyc + 4 * D;
                sb_q.push_back(e);
            end
        end
    end

    // Monitor: per-cycle output checks, DONE scoreboard, and the gate model driving C.
    logic prev_done = 1'b0;
    always @(negedge CLK) begin
        int         rel;
        int         k;
        logic [1:0] ev;
        logic       eb, ed, g;
        exp_t       e;
        rel = cyc - m_t;
        eb = 1'b0; ed = 1'b0; ev = 2'd0;
        if (m_active && rel < 4 * D) begin
            eb = 1'b1;
            ev = 2'(rel / D);
        end else if (m_active && rel == 4 * D) begin
            ed = 1'b1;
        end
        check("busy", 32'(BUSY), 32'(eb));
        check("done", 32'(DONE), 32'(ed));
        check("vec", 32'(VEC), 32'(ev));
        check("a", 32'(A), 32'(ev[1]));
        check("b", 32'(B), 32'(ev[0]));
        check("pass", 32'(PASS), 32'(m_pass));
        check("fail_mask", 32'(FAIL_MASK), 32'(m_mask));
        check("done_single", 32'(DONE & prev_done), 32'd0);
        prev_done = DONE;

        if (DONE === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_done: got DONE=1 expected no run pending (cycle %0d)", cyc);
            end else begin
                e = sb_q.pop_front();
                check("sb_mask", 32'(FAIL_MASK), 32'(e.mask));
                check("sb_pass", 32'(PASS), 32'(e.pass));
                check("sb_done_cycle", 32'(cyc), 32'(e.done_edge));
            end
        end

        if (RST_N && m_active && rel < 4 * D) begin
            k = rel / D;
            g = gate(run_mode, A, B);
            if (rel % D == S) C = g ^ run_flip[k];
            else              C = g ^ (run_noise & 1'($urandom));
        end else begin
            C = 1'($urandom);
        end
    end

    task automatic pulse_start();
        @(negedge CLK) START = 1'b1;
        @(negedge CLK) START = 1'b0;
    endtask

    task automatic wait_idle(input bit spam);
        int n = 0;
        while ((m_active || START) && n < 300) begin
            @(negedge CLK);
            n++;
            if (spam && m_active && (cyc - m_t) < 4 * D - 2) START = 1'($urandom);
            else START = 1'b0;
        end
        @(negedge CLK);
        checks++;
        if (n >= 300) begin
            errors++;
            $display("FAIL idle_timeout: got busy after %0d cycles expected idle", n);
        end
    endtask

    task automatic run_one(input int mode, input logic [3:0] flip, input logic noise, input bit spam);
        cfg_mode  = mode;
        cfg_flip  = flip;
        cfg_noise = noise;
        pulse_start();
        wait_idle(spam);
    endtask

    initial begin
        int n;
        #2 RST_N = 1'b0;
        repeat (6) @(negedge CLK) begin
            START      = 1'($urandom);
            CONTINUOUS = 1'($urandom);
        end
        @(negedge CLK);
        START = 1'b0;
        CONTINUOUS = 1'b0;
        RST_N = 1'b1;
        repeat (3) @(negedge CLK);

        run_one(0, 4'b0000, 1'b0, 1'b0);   // good gate
        run_one(1, 4'b0000, 1'b0, 1'b0);   // stuck-at-0 -> 1110
        run_one(0, 4'b0000, 1'b0, 1'b0);   // passes after a failing run
        run_one(2, 4'b0000, 1'b0, 1'b0);   // AND gate -> 0110
        run_one(0, 4'b0100, 1'b0, 1'b0);   // wrong only at vector 2 sample

        for (int r = 0; r < 6; r++)
            run_one(int'($urandom_range(0, 2)), 4'($urandom), 1'b1, 1'b1);

        // Continuous mode with stray START pulses and changing fault config.
        CONTINUOUS = 1'b1;
        cfg_noise  = 1'b1;
        pulse_start();
        for (int i = 0; i < 5 * (4 * D + 1); i++) begin
            @(negedge CLK);
            START = 1'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                cfg_mode = int'($urandom_range(0, 2));
                cfg_flip = 4'($urandom);
            end
        end
        START = 1'b0;
        CONTINUOUS = 1'b0;
        wait_idle(1'b0);

        // Abort during vector 2 after a passing run, then a clean run.
        run_one(0, 4'b0000, 1'b0, 1'b0);
        cfg_mode = 0; cfg_flip = 4'b0001; cfg_noise = 1'b1;
        pulse_start();
        n = 0;
        while (!(m_active && (cyc - m_t) / D == 2 && (cyc - m_t) % D == 3) && n < 200) begin
            @(negedge CLK);
            n++;
        end
        check("reach_vec2", 32'(n < 200), 32'd1);
        #2 RST_N = 1'b0;
        #1;
        check("async_a", 32'(A), 32'd0);
        check("async_b", 32'(B), 32'd0);
        check("async_vec", 32'(VEC), 32'd0);
        check("async_busy", 32'(BUSY), 32'd0);
        check("async_done", 32'(DONE), 32'd0);
        check("async_pass", 32'(PASS), 32'd0);
        check("async_mask", 32'(FAIL_MASK), 32'd0);
        repeat (3) @(negedge CLK);
        RST_N = 1'b1;
        repeat (2) @(negedge CLK);
        run_one(0, 4'b0000, 1'b1, 1'b1);

        repeat (3) @(negedge CLK);
        check("queue_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got no completion expected finish within bound");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/or_selftest_seq.md
# or_selftest_seq

Self-test sequencer for the two-input OR gate. On request it drives the gate's `A`/`B` inputs through all four input combinations, holding each for a programmable dwell. It samples the gate output `C` at a fixed settle point within each dwell and compares it against the expected `A|B`. It reports a per-vector failure mask and a pass flag, and sits between the board-level start/LED logic and the OR gate instance.

## Interface
- `DWELL`, 8, cycles each vector is held; legal range ≥ `SETTLE`+1 and < 2^`CNT_W`.
- `SETTLE`, 2, cycle index within a dwell at which `C` is sampled; ≥ 1.
- `CNT_W`, 16, dwell counter width.
- `CLK` input 1: single system clock; all state updates on its rising edge.
- `RST_N` input 1: asynchronous active-low reset.
- `START` input 1: request a run; sampled only in IDLE and FINISH.
- `CONTINUOUS` input 1: when high, a new run starts automatically after FINISH.
- `C` input 1: output of the OR gate under test.
- `A` output 1: gate input A, equal to `VEC[1]` while running.
- `B` output 1: gate input B, equal to `VEC[0]` while running.
- `VEC` output 2: index of the current vector (0..3).
- `BUSY` output 1: high while a run is in progress.
- `DONE` output 1: one-cycle pulse when a run completes.
- `PASS` output 1: result of the last completed run; 1 = all four vectors correct.
- `FAIL_MASK` output 4: bit k set if vector k miscompared in the current/last run.

## Operation
- States:
  - IDLE: no run in progress.
  - RUN: vectors being applied and sampled.
  - FINISH: one cycle at the end of each run.
- Reset (async, immediate): state IDLE. `A`, `B`, `VEC`, `BUSY`, `DONE`, `PASS` and `FAIL_MASK` are all 0. The dwell counter is 0.
- IDLE:
  - `A`=`B`=0, `BUSY`=0.
  - `START`=1 → RUN with `VEC`=0, counter=0 and `FAIL_MASK` cleared to 0000. `PASS` holds its old value.
- RUN:
  - The counter increments every cycle, 0..`DWELL`-1.
  - When counter == `SETTLE`: `FAIL_MASK[VEC]` ← (`C` != (`A`|`B`)). `A`/`B` are registered outputs, so the expected value is taken from them.
  - When counter == `DWELL`-1 and `VEC`<3: `VEC` increments and the counter resets to 0.
  - When counter == `DWELL`-1 and `VEC`==3: go to FINISH.
  - `START` is ignored in RUN.
- FINISH (exactly one cycle):
  - `DONE`=1, `BUSY`=0.
  - `PASS` ← (`FAIL_MASK`==0), using the final mask including vector 3's sample.
  - `A`, `B` and `VEC` return to 0.
  - Next state: if `START` or `CONTINUOUS` is high, RUN (as from IDLE, mask cleared); otherwise IDLE.
- `FAIL_MASK` holds its value after FINISH until the next run starts.
- `C` is sampled as-is; any synchronisation of `C` is outside this block.
- Reset asserted mid-run aborts the run. No `DONE` is produced and `PASS` returns to 0.

## Timing
- `START` sampled high at edge t → `BUSY`=1, `A`=`B`=0, `VEC`=0 after edge t.
- Vector k is driven for cycles t+1+k·`DWELL` through t+(k+1)·`DWELL`.
- `C` for vector k is sampled at edge t+1+k·`DWELL`+`SETTLE`.
- The FINISH cycle, with `DONE`=1, follows edge t+4·`DWELL`.
- In continuous mode, the next run's `BUSY` rises after edge t+4·`DWELL`+1, giving a period of 4·`DWELL`+1 cycles.
- `DONE` is never high for more than one consecutive cycle.
- `PASS` changes only in the FINISH cycle or on reset.
- All outputs are registered, with no combinational path from inputs to outputs.

## Test plan
- Reset: hold `RST_N`=0 with random inputs → all outputs 0. Assert `RST_N`=0 asynchronously between clock edges → outputs clear without waiting for an edge.
- Good gate (`C`=`A`|`B`), `DWELL`=8, `SETTLE`=2, single `START` pulse → `A`,`B` step through 00, 01, 10, 11 for 8 cycles each. `DONE` pulses 32 cycles after the first `BUSY` cycle, with `PASS`=1 and `FAIL_MASK`=0000.
- Fault injection:
  - `C` stuck at 0 → `FAIL_MASK`=1110, `PASS`=0.
  - `C`=`A`&`B` → `FAIL_MASK`=0110, `PASS`=0.
  - `C`=`A`|`B` except forced wrong only at the sample edge of vector 2 → `FAIL_MASK`=0100.
- Reset mid-run during vector 2 → outputs clear immediately with no `DONE`. A following `START` yields a full, correct 4-vector run.
- `CONTINUOUS`=1 → `DONE` pulses every 33 cycles, and `FAIL_MASK` is cleared at each run start. Extra `START` pulses during RUN are ignored, leaving pulse spacing unchanged.
- Run 1 fails (stuck-at-0), then run 2 passes → `PASS` reads 0 until run 2's FINISH cycle, then 1.
